// File: rtl/qspi_axi_pkg.sv
// qspi_axi_pkg: AXI4-lite definitions shared by the controller's read and write blocks.
//   RESP_*      : AXI response encodings
//   state_e     : transfer FSM states
//   WORD_BYTES  : byte stride between consecutive words
//   beat_count  : number of word beats needed to cover a byte length
package qspi_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        FIN
    } state_e;

    // Rounds up to whole words; the 17-bit sum keeps 16'hFFFF from wrapping.
    function automatic logic [15:0] beat_count(input logic [15:0] size);
        logic [16:0] s;
        s = {1'b0, size} + 17'd3;
        return {1'b0, s[16:2]};
    endfunction

endpackage

// File: rtl/axi_read_block_if.sv
// axi_read_block_if: AXI4-lite read channels (AR and R).
//   master : initiator side (drives araddr/arvalid/arprot/rready)
//   slave  : target side (drives arready/rdata/rresp/rvalid)
interface axi_read_block_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [2:0]        arprot;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, arprot, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, arprot, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_read_block.sv
// axi_read_block: AXI4-lite read initiator streaming consecutive words into a FIFO.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : one-cycle request, honoured only when idle
//   addr, transfer_size : start byte address (word aligned internally), length in bytes
//   bus                 : AXI4-lite AR/R channels, one read outstanding at a time
//   fifo_wdata/wr_en    : push port towards the TX FIFO, fifo_full back-pressures R
//   busy, done, error   : status; done/error are single-cycle pulses
module axi_read_block
    import qspi_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       transfer_size,
    axi_read_block_if.master  bus,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              abort_q, abort_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       beats;
    logic              r_accept;

    assign beats       = beat_count(transfer_size);
    assign bus.rready  = (state_q == DATA) && !fifo_full;
    assign r_accept    = bus.rvalid && bus.rready;
    assign fifo_wr_en  = r_accept && (bus.rresp == RESP_OKAY);
    assign fifo_wdata  = bus.rdata;
    assign bus.araddr  = araddr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.arprot  = 3'b000;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        remaining_d = remaining_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    // A zero-length request still completes with a done pulse.
                    if (beats != 16'd0) begin
                        araddr_d    = addr & ~ADDR_W'(3);
                        remaining_d = beats;
                        arvalid_d   = 1'b1;
                        state_d     = ADDR;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ADDR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (r_accept) begin
                    if (bus.rresp == RESP_OKAY) begin
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = FIN;
                        end else begin
                            araddr_d  = araddr_q + ADDR_W'(WORD_BYTES);
                            arvalid_d = 1'b1;
                            state_d   = ADDR;
                        end
                    end else begin
                        abort_d = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                error_d = abort_q;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            remaining_q <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            remaining_q <= remaining_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_read_block.sv
// tb_axi_read_block: randomized AXI4-lite slave, FIFO back-pressure and transfer-level model.
//   The slave serves word_at(address); each transfer is predicted as a list of word
//   addresses and pushed words, then compared with what the monitor observed.
module tb_axi_read_block;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic [15:0] transfer_size;
    logic [31:0] fifo_wdata;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        busy;
    logic        done;
    logic        error;

    axi_read_block_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_read_block #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .addr          (addr),
        .transfer_size (transfer_size),
        .bus           (bus),
        .fifo_wdata    (fifo_wdata),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // slave knobs
    int ar_dly_max = 0;
    int r_dly_max  = 0;
    int full_max   = 0;
    int r_fix      = -1;
    int full_fix   = -1;
    int ar_cnt     = 0;
    int cur_err_beat = -1;
    int beat_no    = 0;

    // monitor results
    logic [31:0] got_ar[$];
    logic [31:0] got_push[$];
    int          got_done = 0;
    logic        got_err  = 1'b0;
    int          arv_cycles = 0;
    int          stall_cycles = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // AXI4-lite slave with random AR/R latency and FIFO-full back-pressure
    initial begin
        int          r_cnt;
        int          full_cnt;
        bit          pending;
        logic [31:0] pend_addr;
        logic        s_rst, s_arhs, s_rhs, s_arv;
        logic [31:0] s_addr;
        r_cnt = 0; full_cnt = 0; pending = 0; pend_addr = 0;
        bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            s_rst  = rst_n;
            s_arhs = bus.arvalid && bus.arready;
            s_rhs  = bus.rvalid && bus.rready;
            s_arv  = bus.arvalid;
            s_addr = bus.araddr;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                pending = 0; bus.rvalid = 1'b0; fifo_full = 1'b0; ar_cnt = 0; bus.arready = 1'b1;
            end else begin
                if (s_rhs) begin
                    bus.rvalid = 1'b0; pending = 0; fifo_full = 1'b0; beat_no++;
                end
                if (s_arhs) begin
                    pending = 1; pend_addr = s_addr;
                    r_cnt  = (r_fix >= 0) ? r_fix : int'($urandom_range(0, r_dly_max));
                    ar_cnt = int'($urandom_range(0, ar_dly_max));
                end else if (s_arv && ar_cnt > 0) begin
                    ar_cnt--;
                end
                bus.arready = (ar_cnt == 0);
                if (pending && !bus.rvalid) begin
                    if (r_cnt > 0) r_cnt--;
                    else begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = word_at(pend_addr);
                        bus.rresp  = (beat_no == cur_err_beat) ? 2'b10 : 2'b00;
                        full_cnt   = (full_fix >= 0) ? full_fix : int'($urandom_range(0, full_max));
                    end
                end
                if (bus.rvalid) begin
                    fifo_full = (full_cnt > 0);
                    if (full_cnt > 0) full_cnt--;
                end
            end
        end
    end

    // bus monitor: records handshakes/pushes/done and checks protocol rules every cycle
    logic        ar_hold = 1'b0;
    logic [31:0] hold_addr = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.arvalid && bus.arready) got_ar.push_back(bus.araddr);
            if (bus.arvalid) arv_cycles++;
            if (fifo_wr_en) got_push.push_back(fifo_wdata);
            if (bus.rvalid && !bus.rready) stall_cycles++;
            if (done) begin got_done++; got_err = error; end
            if (fifo_full) begin
                ntests++;
                if (bus.rready !== 1'b0) begin
                    nfail++; $display("FAIL rready_while_full: rready=%b required 0", bus.rready);
                end
            end
            if (ar_hold) begin
                ntests++;
                if (bus.arvalid !== 1'b1 || bus.araddr !== hold_addr) begin
                    nfail++;
                    $display("FAIL ar_stable: arvalid=%b araddr=%h required 1/%h", bus.arvalid, bus.araddr, hold_addr);
                end
            end
            if (error && !done) begin
                ntests++; nfail++; $display("FAIL error_without_done: error=1 done=0");
            end
            if (bus.arprot !== 3'b000) begin
                ntests++; nfail++; $display("FAIL arprot: got %b required 000", bus.arprot);
            end
            ar_hold   = bus.arvalid && !bus.arready;
            hold_addr = bus.araddr;
        end else begin
            ar_hold = 1'b0;
        end
    end

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Runs one transfer and compares it with the transfer-level prediction.
    task automatic run_xfer(input logic [31:0] a, input logic [15:0] size, input int err_beat,
                            input bit extra, input int lat, input string name);
        int          n, n_ar, n_push, cyc, budget, bad;
        bit          exp_err;
        logic [31:0] base;
        n       = (int'(size) + 3) / 4;
        base    = a & 32'hFFFF_FFFC;
        exp_err = (err_beat >= 0 && err_beat < n);
        n_ar    = exp_err ? err_beat + 1 : n;
        n_push  = exp_err ? err_beat : n;
        budget  = 40 * n + 60;
        cur_err_beat = err_beat;
        beat_no = 0;
        got_ar.delete(); got_push.delete();
        got_done = 0; got_err = 1'b0; arv_cycles = 0; stall_cycles = 0;
        start = 1'b1; addr = a; transfer_size = size;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; addr = $urandom; transfer_size = 16'($urandom);
                ntests++;
                if (busy !== 1'b1) begin
                    nfail++; $display("FAIL %s busy_after_start: got %b required 1", name, busy);
                end
            end
            if (extra && cyc == 3) begin
                start = 1'b1; addr = $urandom; transfer_size = 16'($urandom_range(4, 64));
            end
            if (extra && cyc == 4) start = 1'b0;
        end while (got_done == 0 && cyc < budget);
        start = 1'b0;
        ntests++;
        if (got_done == 0) begin
            nfail++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
            pulse_reset();
            return;
        end
        if (lat >= 0) begin
            ntests++;
            if (cyc != lat) begin
                nfail++; $display("FAIL %s latency: got %0d cycles required %0d", name, cyc, lat);
            end
        end
        ntests++;
        if (busy !== 1'b0) begin
            nfail++; $display("FAIL %s busy_at_done: got %b required 0", name, busy);
        end
        ntests++;
        if (got_err !== exp_err) begin
            nfail++; $display("FAIL %s error: got %b required %b", name, got_err, exp_err);
        end
        repeat (3) begin @(negedge clk); #1; end
        ntests++;
        if (got_done != 1) begin
            nfail++; $display("FAIL %s done_count: got %0d required 1", name, got_done);
        end
        ntests++;
        bad = -1;
        if (got_ar.size() != n_ar) bad = -2;
        else foreach (got_ar[i]) if (bad == -1 && got_ar[i] !== base + 32'(4 * i)) bad = i;
        if (bad != -1) begin
            nfail++;
            if (bad == -2) $display("FAIL %s ar_count: got %0d required %0d", name, got_ar.size(), n_ar);
            else $display("FAIL %s araddr[%0d]: got %h required %h", name, bad, got_ar[bad], base + 32'(4 * bad));
        end
        ntests++;
        bad = -1;
        if (got_push.size() != n_push) bad = -2;
        else foreach (got_push[i]) if (bad == -1 && got_push[i] !== word_at(base + 32'(4 * i))) bad = i;
        if (bad != -1) begin
            nfail++;
            if (bad == -2) $display("FAIL %s push_count: got %0d required %0d", name, got_push.size(), n_push);
            else $display("FAIL %s push[%0d]: got %h required %h", name, bad, got_push[bad], word_at(base + 32'(4 * bad)));
        end
        if (n == 0) begin
            ntests++;
            if (arv_cycles != 0) begin
                nfail++; $display("FAIL %s arvalid_zero_len: got %0d cycles required 0", name, arv_cycles);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        ntests++;
        if (bus.araddr !== 32'h0 || bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || fifo_wr_en !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            nfail++;
            $display("FAIL %s: araddr=%h arvalid=%b rready=%b wr_en=%b busy=%b done=%b error=%b required all 0",
                     name, bus.araddr, bus.arvalid, bus.rready, fifo_wr_en, busy, done, error);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; addr = '0; transfer_size = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_three_words();
        run_xfer(32'h1000_0006, 16'd12, -1, 1'b0, 8, "three_words");
    endtask

    task automatic test_partial_word();
        run_xfer(32'h0, 16'd5, -1, 1'b0, 6, "partial_word");
    endtask

    task automatic test_zero_len();
        run_xfer(32'h2000_0000, 16'd0, -1, 1'b0, 2, "zero_len");
    endtask

    task automatic test_ar_stall();
        ar_cnt = 5;
        run_xfer(32'h0000_0040, 16'd4, -1, 1'b0, 9, "ar_stall");
    endtask

    task automatic test_fifo_full();
        full_fix = 4;
        run_xfer(32'h0000_0100, 16'd4, -1, 1'b0, 8, "fifo_full");
        full_fix = -1;
        ntests++;
        if (stall_cycles != 4) begin
            nfail++; $display("FAIL fifo_full stall_cycles: got %0d required 4", stall_cycles);
        end
    endtask

    task automatic test_resp_error();
        run_xfer(32'h0000_0200, 16'd8, 0, 1'b0, 4, "resp_error");
    endtask

    task automatic test_reset_mid();
        int w;
        r_fix = 6;
        beat_no = 0; cur_err_beat = -1;
        got_ar.delete();
        start = 1'b1; addr = 32'h0000_0300; transfer_size = 16'd16;
        @(negedge clk); #1;
        start = 1'b0;
        w = 0;
        while (got_ar.size() == 0 && w < 50) begin @(negedge clk); #1; w++; end
        ntests++;
        if (got_ar.size() == 0) begin
            nfail++; $display("FAIL reset_mid: no AR handshake within 50 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        r_fix = -1;
        @(negedge clk); #1;
        run_xfer(32'h0000_0400, 16'd8, -1, 1'b0, 6, "after_reset");
    endtask

    task automatic test_random();
        int          n, eb;
        logic [15:0] sz;
        ar_dly_max = 3; r_dly_max = 3; full_max = 3;
        for (int k = 0; k < 25; k++) begin
            sz = 16'($urandom_range(0, 64));
            n  = (int'(sz) + 3) / 4;
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            run_xfer($urandom, sz, eb, (n >= 2 && eb != 0), -1, $sformatf("random%0d", k));
        end
        ar_dly_max = 0; r_dly_max = 0; full_max = 0;
    endtask

    task automatic test_max_size();
        run_xfer(32'hFFFF_FF01, 16'hFFFF, -1, 1'b0, 2 * 16384 + 2, "max_size_wrap");
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_partial_word();
        test_zero_len();
        test_ar_stall();
        test_fifo_full();
        test_resp_error();
        test_reset_mid();
        test_random();
        test_max_size();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
